// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: takes bytes out of the UART receiver's one-byte buffer using the
// data_ready/data_read handshake. Each byte is tagged with the receiver's error
// flags and stored in a first-word-fall-through FIFO, so the host can read in bursts.
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_ready,
    input  logic [7:0]        rx_data,
    input  logic              overrun_error,
    input  logic              framing_error,
    output logic              data_read,
    input  logic              fifo_rd_en,
    output logic [9:0]        fifo_rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              stall_seen
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                stall_q, stall_d;
    logic                data_read_q, data_read_d;
    logic [9:0]          mem_q [DEPTH];
    logic [9:0]          mem_d [DEPTH];
    logic                wr_en, rd_en;

    // The flags come from the registered count. A full FIFO therefore blocks a write even when a pop happens on the same edge.
    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign fifo_count   = count_q;
    assign stall_seen   = stall_q;
    assign data_read    = data_read_q;
    assign fifo_rd_data = mem_q[rd_ptr_q];

    // Capture FSM, pointers, occupancy count and the sticky stall flag: next-state logic
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        mem_d    = mem_q;
        wr_en    = 1'b0;
        rd_en    = fifo_rd_en && !fifo_empty;

        unique case (state_q)
            IDLE: begin
                if (data_ready) begin
                    if (!fifo_full) begin
                        wr_en   = 1'b1;
                        state_d = ACK;
                    end else begin
                        // The byte stays in the receiver. Its overrun flag arrives with the next accepted byte.
                        stall_d = 1'b1;
                    end
                end
            end
            ACK:      state_d = WAIT_CLR;
            // Wait for data_ready to drop so the same byte cannot be captured twice.
            WAIT_CLR: if (!data_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (wr_en) begin
            mem_d[wr_ptr_q] = {overrun_error, framing_error, rx_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Registered acknowledge: high exactly for the cycle spent in ACK
        data_read_d = (state_d == ACK);
    end

    // State registers. An asynchronous reset drops every stored entry and any handshake in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= 1'b0;
            data_read_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
            data_read_q <= data_read_d;
            mem_q       <= mem_d;
        end
    end

endmodule
